// File: rtl/demux1a2_buf_pkg.sv
// Shared definitions for the buffered 1:2 demultiplexer and related buffered blocks.
package demux1a2_buf_pkg;

    // Channel select encoding carried on in_sel
    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux1a2_buf_if.sv
// Handshake bundle for demux1a2_buf: one tagged input stream, two buffered outputs, debug counters.
interface demux1a2_buf_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a_data;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_b_data;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    // Producer/consumer side: drives the input stream and the output readies
    modport master (
        output in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        input  in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_sel, in_valid, out_a_ready, out_b_ready,
        output in_ready, out_a_data, out_a_valid, out_b_data, out_b_valid, cnt_a, cnt_b
    );
endinterface

// File: rtl/demux1a2_buf_fifo_sync_small.sv
// Small synchronous FIFO with a registered head word (show-ahead), write-through when empty.
module fifo_sync_small
    import demux1a2_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                     (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = dout_reg;

    // Pointer advance for this cycle's push/pop
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
    end

    // Storage array, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= din;
        end
    end

    // Pointers and registered head; head comes from din when the new entry becomes the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (rd_ptr_next != wr_ptr_next) begin
                if (rd_ptr_next == wr_ptr_reg) begin
                    dout_reg <= din;
                end else begin
                    dout_reg <= mem[rd_ptr_next[IDX_W-1:0]];
                end
            end
        end
    end
endmodule

// File: rtl/demux1a2_buf.sv
// Buffered 1:2 demultiplexer: routes tagged words into per-channel FIFOs and counts accepts.
module demux1a2_buf
    import demux1a2_buf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1a2_buf_if.slave  bus
);
    logic [1:0]       full, empty, push, pop, out_ready;
    logic [WIDTH-1:0] head [2];
    logic             accept;

    // Ready depends only on the addressed FIFO; no pass-through from the output side
    assign bus.in_ready = ~full[bus.in_sel];
    assign accept       = bus.in_valid & ~full[bus.in_sel];
    assign push[0]      = accept & (bus.in_sel == DEMUX_SEL_A);
    assign push[1]      = accept & (bus.in_sel == DEMUX_SEL_B);
    assign out_ready[0] = bus.out_a_ready;
    assign out_ready[1] = bus.out_b_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;

            assign pop[gi] = out_ready[gi] & ~empty[gi];

            fifo_sync_small #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push[gi]),
                .din   (bus.in_data),
                .full  (full[gi]),
                .pop   (pop[gi]),
                .dout  (head[gi]),
                .empty (empty[gi])
            );

            // Accepted-word counter, wraps silently
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (push[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.out_a_data  = head[0];
    assign bus.out_a_valid = ~empty[0];
    assign bus.out_b_data  = head[1];
    assign bus.out_b_valid = ~empty[1];
    assign bus.cnt_a       = g_ch[0].cnt_reg;
    assign bus.cnt_b       = g_ch[1].cnt_reg;
endmodule
